// File: rtl/eject_sink_monitor.sv
// Eject-port sink: programmable back-pressure, packet framing and handshake
// checking, flit/packet counters and a no-progress watchdog.
module eject_sink_monitor #(
  parameter int unsigned DW         = 32,
  parameter int unsigned BP_PERIOD  = 50,
  parameter int unsigned WDOG_LIMIT = 10000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DW-1:0]    data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             bp_en,
  output logic [CNT_W-1:0] flit_cnt_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic             pkt_done_o,
  output logic             in_pkt_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic             stall_o
);

  localparam int unsigned BP_W = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;
  localparam int unsigned WD_W = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
  localparam logic [BP_W-1:0] BP_LAST = BP_W'(BP_PERIOD - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_LIMIT);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  localparam logic [1:0] E_ORPHAN = 2'd1;
  localparam logic [1:0] E_NESTED = 2'd2;
  localparam logic [1:0] E_HSHAKE = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BP_W-1:0] bp_cnt_q;
  logic            phase_q, phase_d;
  logic            acc;
  logic [1:0]      ftype;
  logic            pkt_end;
  logic            frame_err;
  logic [1:0]      frame_code;
  logic            stall_q;
  logic [DW-1:0]   data_q;
  logic            hs_err;
  logic [WD_W-1:0] wd_cnt_q;

  assign acc      = valid_i & ready_o;
  assign ftype    = data_i[DW-1:DW-2];
  assign in_pkt_o = (state_q == IN_PKT);

  // Phase flips when the back-pressure counter wraps.
  always_comb begin
    phase_d = phase_q;
    if (bp_cnt_q == BP_LAST) begin
      phase_d = ~phase_q;
    end
  end

  // Free-running back-pressure counter and phase; ready is registered so it
  // never depends on valid_i.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bp_cnt_q <= '0;
      phase_q  <= 1'b0;
      ready_o  <= 1'b0;
    end else begin
      if (bp_cnt_q == BP_LAST) begin
        bp_cnt_q <= '0;
      end else begin
        bp_cnt_q <= bp_cnt_q + BP_W'(1);
      end
      phase_q <= phase_d;
      ready_o <= bp_en ? phase_d : 1'b1;
    end
  end

  // Framing decode: next state, packet completion and framing errors on accept.
  always_comb begin
    state_d    = state_q;
    pkt_end    = 1'b0;
    frame_err  = 1'b0;
    frame_code = '0;
    if (acc) begin
      case (state_q)
        IDLE: begin
          case (ftype)
            T_HEAD:   state_d = IN_PKT;
            T_SINGLE: pkt_end = 1'b1;
            default: begin
              frame_err  = 1'b1;
              frame_code = E_ORPHAN;
            end
          endcase
        end
        IN_PKT: begin
          case (ftype)
            T_BODY: state_d = IN_PKT;
            T_TAIL: begin
              state_d = IDLE;
              pkt_end = 1'b1;
            end
            T_HEAD: begin
              // Old packet is dropped uncounted; the new head opens a packet.
              state_d    = IN_PKT;
              frame_err  = 1'b1;
              frame_code = E_NESTED;
            end
            default: begin
              state_d    = IDLE;
              pkt_end    = 1'b1;
              frame_err  = 1'b1;
              frame_code = E_NESTED;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Framing state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the offered flit on every stalled cycle for the stability check.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= 1'b0;
      data_q  <= '0;
    end else begin
      stall_q <= valid_i & ~ready_o;
      if (valid_i & ~ready_o) begin
        data_q <= data_i;
      end
    end
  end

  // After a stall the sender must keep valid high with unchanged data.
  assign hs_err = stall_q & (~valid_i | (data_i != data_q));

  // Latch the first error only; a handshake violation outranks framing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else if (!err_o && (hs_err || frame_err)) begin
      err_o      <= 1'b1;
      err_code_o <= hs_err ? E_HSHAKE : frame_code;
    end
  end

  // Flit/packet counters (wrap naturally) and the packet-done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flit_cnt_o <= '0;
      pkt_cnt_o  <= '0;
      pkt_done_o <= 1'b0;
    end else begin
      if (acc) begin
        flit_cnt_o <= flit_cnt_o + CNT_W'(1);
      end
      if (pkt_end) begin
        pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
      end
      pkt_done_o <= pkt_end;
    end
  end

  // Watchdog: count no-progress cycles inside a packet, saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt_q <= '0;
    end else if (acc || (state_q == IDLE)) begin
      wd_cnt_q <= '0;
    end else if (wd_cnt_q != WD_MAX) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  // Sticky stall flag once the watchdog saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_o <= 1'b0;
    end else if (wd_cnt_q == WD_MAX) begin
      stall_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eject_sink_monitor.sv
// Self-checking bench for eject_sink_monitor: scoreboard of expected packet
// completions plus directed checks of ready shaping, errors and watchdog.
module tb_eject_sink_monitor;

  localparam int unsigned DW  = 16;
  localparam int unsigned P   = 4;
  localparam int unsigned WDL = 16;
  localparam int unsigned CW  = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          bp_en;
  logic          ready_o;
  logic [CW-1:0] flit_cnt_o;
  logic [CW-1:0] pkt_cnt_o;
  logic          pkt_done_o;
  logic          in_pkt_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic          stall_o;

  eject_sink_monitor #(
    .DW(DW),
    .BP_PERIOD(P),
    .WDOG_LIMIT(WDL),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .bp_en(bp_en),
    .flit_cnt_o(flit_cnt_o),
    .pkt_cnt_o(pkt_cnt_o),
    .pkt_done_o(pkt_done_o),
    .in_pkt_o(in_pkt_o),
    .err_o(err_o),
    .err_code_o(err_code_o),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pkts;
    logic [31:0] flits;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_flits = 0;
  int   exp_pkts = 0;
  logic exp_in_pkt = 1'b0;
  int   done_pulses = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop one expected completion per pkt_done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && pkt_done_o === 1'b1) begin
      done_pulses++;
      if (sb.size() == 0) begin
        check_val("pkt_done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("sb_pkt_cnt", pkt_cnt_o, e.pkts);
        check_val("sb_flit_cnt", flit_cnt_o, e.flits);
      end
    end
  end

  // Offer a flit and predict its effect from the framing rules.
  task automatic drive_flit(input logic [1:0] t, input logic [13:0] pl);
    valid_i = 1'b1;
    data_i  = {t, pl};
    exp_flits++;
    case (t)
      2'b01: exp_in_pkt = 1'b1;
      2'b11: begin
        exp_in_pkt = 1'b0;
        exp_pkts++;
        sb.push_back('{32'(exp_pkts), 32'(exp_flits)});
      end
      2'b10: begin
        if (exp_in_pkt) begin
          exp_in_pkt = 1'b0;
          exp_pkts++;
          sb.push_back('{32'(exp_pkts), 32'(exp_flits)});
        end
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [1:0] t, input logic [13:0] pl);
    int unsigned n;
    drive_flit(t, pl);
    n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (ready_o !== 1'b1) check_val("send_timeout", 0, 1);
    @(posedge clk); #1;
    check_val("in_pkt", in_pkt_o, exp_in_pkt);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_ready"}, ready_o, 0);
    check_val({tag, "_flit"}, flit_cnt_o, 0);
    check_val({tag, "_pkt"}, pkt_cnt_o, 0);
    check_val({tag, "_done"}, pkt_done_o, 0);
    check_val({tag, "_inpkt"}, in_pkt_o, 0);
    check_val({tag, "_err"}, err_o, 0);
    check_val({tag, "_code"}, err_code_o, 0);
    check_val({tag, "_stall"}, stall_o, 0);
  endtask

  // Drain, reset, release at posedge+1 so the next edge is edge 1.
  task automatic do_reset(input logic bp);
    idle(2);
    check_val("sb_drain", sb.size(), 0);
    rstn  = 1'b0;
    bp_en = bp;
    #1;
    check_zero("rst_async");
    @(posedge clk); #1;
    check_zero("rst_held");
    sb.delete();
    exp_flits   = 0;
    exp_pkts    = 0;
    exp_in_pkt  = 1'b0;
    done_pulses = 0;
    rstn = 1'b1;
  endtask

  function automatic logic [1:0] ty(input int i);
    if (i == 0) return 2'b01;
    if (i == 9) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int   c;
    int   idx;
    logic a;
    valid_i = 1'b0;
    data_i  = '0;
    bp_en   = 1'b0;

    // Three packets, no back-pressure, valid held high.
    do_reset(1'b0);
    send(2'b01, 14'd1); send(2'b00, 14'd2); send(2'b00, 14'd3); send(2'b10, 14'd4);
    send(2'b11, 14'd5);
    send(2'b01, 14'd6); send(2'b10, 14'd7);
    idle(3);
    check_val("t1_flit", flit_cnt_o, 7);
    check_val("t1_pkt", pkt_cnt_o, 3);
    check_val("t1_pulses", done_pulses, 3);
    check_val("t1_err", err_o, 0);
    check_val("t1_stall", stall_o, 0);

    // Back-pressure with period 4, continuous valid on a 10-flit packet.
    do_reset(1'b1);
    drive_flit(ty(0), 14'd0);
    c = 0;
    idx = 0;
    while (idx < 10 && c < 100) begin
      @(negedge clk);
      check_val("bp_ready", ready_o, ((c / P) % 2) == 1);
      a = ready_o;
      @(posedge clk); #1;
      c++;
      if (a) begin
        idx++;
        if (idx < 10) drive_flit(ty(idx), 14'(idx));
        else valid_i = 1'b0;
      end
      check_val("bp_flit_cnt", flit_cnt_o, idx);
    end
    check_val("bp_all_accepted", idx, 10);
    idle(3);
    check_val("t2_pkt", pkt_cnt_o, 1);
    check_val("t2_err", err_o, 0);
    check_val("t2_stall", stall_o, 0);

    // Orphan body, then head, nested head, tail: first error is kept.
    do_reset(1'b0);
    drive_flit(2'b00, 14'd9);
    @(posedge clk); #1;
    check_val("t3_pre_err", err_o, 0);
    check_val("t3_pre_flit", flit_cnt_o, 0);
    @(posedge clk); #1;
    check_val("t3_err", err_o, 1);
    check_val("t3_code_now", err_code_o, 1);
    check_val("t3_flit_now", flit_cnt_o, 1);
    send(2'b01, 14'd1); send(2'b01, 14'd2); send(2'b10, 14'd3);
    idle(3);
    check_val("t3_code", err_code_o, 1);
    check_val("t3_pkt", pkt_cnt_o, 1);
    check_val("t3_flit", flit_cnt_o, 4);

    // Data changed while stalled.
    do_reset(1'b1);
    valid_i = 1'b1;
    data_i  = {2'b11, 14'h00AA};
    @(posedge clk); #1;
    check_val("t4_pre_err", err_o, 0);
    data_i = {2'b11, 14'h0055};
    @(posedge clk); #1;
    check_val("t4_err", err_o, 1);
    check_val("t4_code", err_code_o, 3);
    idle(6);
    check_val("t4_code_hold", err_code_o, 3);
    check_val("t4_flit", flit_cnt_o, 0);

    // Valid withdrawn while stalled.
    do_reset(1'b1);
    valid_i = 1'b1;
    data_i  = {2'b01, 14'h0123};
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    check_val("t4b_code", err_code_o, 3);

    // Watchdog: head, then silence for WDOG_LIMIT cycles.
    do_reset(1'b0);
    send(2'b01, 14'd1);
    valid_i = 1'b0;
    for (int k = 1; k <= WDL; k++) begin
      @(posedge clk); #1;
      check_val("wd_quiet", stall_o, 0);
    end
    @(posedge clk); #1;
    check_val("wd_trip", stall_o, 1);
    send(2'b00, 14'd2); send(2'b10, 14'd3);
    idle(3);
    check_val("wd_hold", stall_o, 1);
    check_val("t5_pkt", pkt_cnt_o, 1);
    check_val("t5_err", err_o, 0);

    // Reset in the middle of a packet, then a tail.
    do_reset(1'b0);
    send(2'b01, 14'd1); send(2'b00, 14'd2); send(2'b00, 14'd3);
    do_reset(1'b0);
    send(2'b10, 14'd4);
    idle(3);
    check_val("t6_err", err_o, 1);
    check_val("t6_code", err_code_o, 1);
    check_val("t6_pkt", pkt_cnt_o, 0);
    check_val("t6_flit", flit_cnt_o, 1);

    idle(2);
    check_val("sb_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eject_sink_monitor.md
Name: eject_sink_monitor

Overview:
Synthesizable sink for one NoC eject port, the receiving end of the valid/ready flit stream leaving `system` (data_o_eject/valid_o_eject/ready_i_eject). It generates programmable back-pressure, checks packet framing and handshake legality, and counts flits and packets. It also raises a sticky stall flag when a packet stops making progress (deadlock watchdog). One instance sits on each of the `EPN eject ports in on-board and emulation builds.

Parameters:
DW, `DW, flit width; matches the network flit width
BP_PERIOD, 50, cycles per ready phase when back-pressure is enabled; legal range ≥1
WDOG_LIMIT, 10000, no-progress cycles inside a packet before stall_o asserts
CNT_W, 32, width of the flit and packet counters

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
data_i  in  DW  eject flit; data_i[DW-1:DW-2] = type: 01 head, 00 body, 10 tail, 11 single (head+tail)
valid_i  in  1  flit valid from the network
ready_o  out  1  sink ready (registered)
bp_en  in  1  1 = toggle ready every BP_PERIOD cycles; 0 = always ready
flit_cnt_o  out  CNT_W  accepted flits
pkt_cnt_o  out  CNT_W  completed packets (tail or single accepted)
pkt_done_o  out  1  one-cycle pulse, cycle after a tail/single is accepted
in_pkt_o  out  1  FSM in IN_PKT
err_o  out  1  sticky error flag
err_code_o  out  2  first error latched: 1 orphan, 2 nested head, 3 handshake violation
stall_o  out  1  sticky watchdog flag

Behaviour:
- Reset is asynchronous, active low, and applies to all state. On reset: ready_o=0, counters=0, pkt_done_o=0, in_pkt_o=0, err_o=0, err_code_o=0, stall_o=0, phase=0, bp_cnt=0.
- Accept condition: acc = valid_i & ready_o. Every acc increments flit_cnt_o, including flits that carry a framing error. Counters wrap modulo 2^CNT_W.
- Ready generation:
  - bp_cnt counts 0..BP_PERIOD-1 continuously. At BP_PERIOD-1 it wraps to 0 and phase toggles.
  - ready_o <= bp_en ? next phase : 1.
  - With bp_en=1 after reset, ready_o is low for the first BP_PERIOD cycles, then alternates high/low in BP_PERIOD-cycle phases.
  - With bp_en=0, ready_o=1 from the first clock edge after reset.
  - ready_o never depends combinationally on valid_i.
- Framing FSM. States are IDLE and IN_PKT; the FSM changes only on acc.
  - IDLE + head → IN_PKT.
  - IDLE + single → IDLE; pkt_cnt+1, pkt_done pulse.
  - IDLE + body/tail → IDLE; error 1 (orphan).
  - IN_PKT + body → IN_PKT.
  - IN_PKT + tail → IDLE; pkt_cnt+1, pkt_done pulse.
  - IN_PKT + head → IN_PKT; error 2. The old packet is abandoned and not counted; the new packet starts.
  - IN_PKT + single → IDLE; error 2; pkt_cnt+1, pkt_done pulse.
- Handshake check. A stall is a cycle with valid_i=1 & ready_o=0; the sink registers data_i on each stall. On the next cycle, valid_i=0 or data_i differing from the registered value raises error 3.
- Error latching:
  - err_o and err_code_o latch only the first error, one cycle after detection, and hold until reset.
  - If error 3 and a framing error are detected in the same cycle, code 3 wins.
- Watchdog:
  - wd_cnt clears on acc or when the FSM is in IDLE.
  - Otherwise it increments each cycle while in IN_PKT, saturating at WDOG_LIMIT.
  - When wd_cnt reaches WDOG_LIMIT, stall_o is set the next cycle and held until reset.
  - Back-pressure alone never trips the watchdog as long as WDOG_LIMIT > 2*BP_PERIOD and the network is live.
- Reset mid-packet returns the FSM to IDLE, clears all state and drops ready_o immediately. The first flit after reset, if it is body or tail, is flagged as orphan.

Test Plan:
- bp_en=0; 3 packets: head,body,body,tail / single / head,tail, with valid_i held high → flit_cnt=7, pkt_cnt=3, 3 pkt_done pulses, err_o=0, stall_o=0.
- bp_en=1, BP_PERIOD=4, continuous valid on a 10-flit packet → ready_o low cycles 1-4, high 5-8, low 9-12, and so on; all 10 flits accepted only in ready-high windows, data stable during stalls, err_o=0.
- Body flit sent from IDLE, then head, then head, then tail → err_code_o=1 (first error only) latched one cycle after the body accept; pkt_cnt=1; flit_cnt=4.
- Stall with data 0x…AA, then data changed to 0x…55 while ready_o=0 → err_o=1, err_code_o=3.
- Head accepted, then valid_i=0 for WDOG_LIMIT=16 cycles → stall_o rises in the cycle after wd_cnt reaches 16 and stays high after traffic resumes.
- rstn pulsed low mid-packet after the head and 2 bodies, then a tail sent → all outputs 0 during reset; after reset err_code_o=1, pkt_cnt=0, flit_cnt=1.
